// File: rtl/prod_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// prod_accumulator_pkg
//   Shared definitions for the product accumulator and the multiplier-side
//   drivers that feed it.
//   - state_e   : FSM state encoding (IDLE=0, ACCUM=1, HOLD=2)
//   - cnt_width : width needed to count 0..max_terms terms
// -----------------------------------------------------------------------------
package prod_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Term-counter width: must represent MAX_TERMS itself, hence the +1.
    function automatic int cnt_width(input int max_terms);
        return $clog2(max_terms + 1);
    endfunction

endpackage

// File: rtl/prod_accumulator_acc_adder.sv
// -----------------------------------------------------------------------------
// acc_adder (plus ha / fa cells)
//   Combinational W-bit ripple adder returning {carry, sum}, built from
//   half/full-adder cells.
//   Ports (acc_adder):
//     a_i      in  W   first operand
//     b_i      in  W   second operand
//     sum_o    out W   a_i + b_i modulo 2**W
//     carry_o  out 1   carry out of bit W-1
// -----------------------------------------------------------------------------
module ha (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module acc_adder #(
    parameter int W = 12
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);
    // c_chain[gi] is the carry out of bit gi.
    logic [W-1:0] c_chain;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            if (gi == 0) begin : g_ha
                ha u_ha (
                    .a_i (a_i[gi]),
                    .b_i (b_i[gi]),
                    .s_o (sum_o[gi]),
                    .c_o (c_chain[gi])
                );
            end else begin : g_fa
                fa u_fa (
                    .a_i (a_i[gi]),
                    .b_i (b_i[gi]),
                    .c_i (c_chain[gi-1]),
                    .s_o (sum_o[gi]),
                    .c_o (c_chain[gi])
                );
            end
        end
    endgenerate

    assign carry_o = c_chain[W-1];
endmodule

// File: rtl/prod_accumulator.sv
// -----------------------------------------------------------------------------
// prod_accumulator
//   Accumulates unsigned products into a dot-product sum, one term per
//   accepted beat. A packet closes on in_last or on reaching MAX_TERMS terms;
//   the finished sum is then held on a valid/ready output until consumed.
//   Ports:
//     clk        in   1       rising-edge clock
//     rst_n      in   1       asynchronous active-low reset
//     clr        in   1       synchronous abort (drops packet and held result)
//     in_valid   in   1       product beat valid
//     in_ready   out  1       stage can accept a beat
//     in_prod    in   PROD_W  product value (unsigned)
//     in_last    in   1       beat is the final term of the packet
//     out_valid  out  1       result held on out_sum/out_cnt/out_ovf
//     out_ready  in   1       consumer accepts result
//     out_sum    out  ACC_W   packet sum modulo 2**ACC_W
//     out_cnt    out  CNT_W   number of terms in the packet
//     out_ovf    out  1       some addition in the packet carried out
// -----------------------------------------------------------------------------
module prod_accumulator
    import prod_accumulator_pkg::*;
#(
    parameter  int PROD_W    = 8,
    parameter  int ACC_W     = 12,
    parameter  int MAX_TERMS = 16,
    localparam int CNT_W     = cnt_width(MAX_TERMS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf
);

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [ACC_W-1:0]  add_a;
    logic [ACC_W-1:0]  add_sum;
    logic              add_carry;
    logic [CNT_W-1:0]  cnt_inc;
    logic              accept;
    logic              consume;
    logic              close;

    // Handshake outputs are decoded from state only, so in_ready never
    // depends combinationally on out_ready.
    assign in_ready  = (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);
    assign out_sum   = acc_q;
    assign out_cnt   = cnt_q;
    assign out_ovf   = ovf_q;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    // The first term of a packet starts from zero regardless of acc_q.
    assign add_a   = (state_q == ST_ACCUM) ? acc_q : '0;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign close   = in_last | (cnt_inc == CNT_W'(MAX_TERMS));

    acc_adder #(
        .W (ACC_W)
    ) u_acc_adder (
        .a_i     (add_a),
        .b_i     (ACC_W'(in_prod)),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (clr) begin
            // Abort wins over any concurrent beat or consume.
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        acc_d   = add_sum;
                        cnt_d   = cnt_inc;
                        ovf_d   = 1'b0;
                        state_d = close ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc_d   = add_sum;
                        cnt_d   = cnt_inc;
                        ovf_d   = ovf_q | add_carry;
                        state_d = close ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (consume) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
